ir_fetch_queue: RTL and testbench

//  Parametrised, clocked successor to the multi-cycle CPU's instruction register.

---
 rtl/ir_fetch_queue.sv | 125 ++++++++++++
 tb/tb_ir_fetch_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry {pc,inst} circular buffer whose head is presented as MIPS fields.
// Latency: 1 cycle push-to-head; 0 cycles with IR_FETCH_BYPASS_EN defined (empty-queue bypass).
// Backpressure: in_ready drops when full or flushing, and a same-cycle pop never frees the slot early.
module ir_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_inst,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [5:0]                 inst31_26,
    output logic [25:0]                inst25_0,
    output logic [4:0]                 inst25_21,
    output logic [4:0]                 inst20_16,
    output logic [15:0]                inst15_0,
    output logic [4:0]                 inst15_11,
    output logic [4:0]                 inst10_6,
    output logic [5:0]                 inst5_0,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      inst_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem   [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      last_q;
    logic [PC_W-1:0]  last_pc;

    logic             empty, full, push, pop, store, deq, bypass;
    logic [31:0]      head_inst;
    logic [PC_W-1:0]  head_pc;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        // Explicit wrap so non-power-of-two depths work.
        if (p == PTR_W'(DEPTH - 1))
            return '0;
        return p + 1'b1;
    endfunction

    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_W'(DEPTH));
    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;

`ifdef IR_FETCH_BYPASS_EN
    assign bypass   = empty && in_valid && !flush;
`else
    assign bypass   = 1'b0;
`endif

    assign out_valid = !empty || bypass;
    assign pop       = out_valid && out_ready && !flush;
    // A bypassed word taken in the same cycle never occupies a slot.
    assign store     = push && !(bypass && out_ready);
    assign deq       = pop && !empty;

    always_comb begin
        head_inst = last_q;
        head_pc   = last_pc;
        if (!empty) begin
            head_inst = inst_mem[rd_ptr];
            head_pc   = pc_mem[rd_ptr];
        end else if (bypass) begin
            head_inst = in_inst;
            head_pc   = in_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            inst_mem[wr_ptr] <= in_inst;
            pc_mem[wr_ptr]   <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            last_q  <= '0;
            last_pc <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (store)
                wr_ptr <= ptr_inc(wr_ptr);
            if (deq)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({store, deq})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (pop) begin
                last_q  <= head_inst;
                last_pc <= head_pc;
            end
        end
    end

    assign out_pc    = head_pc;
    assign inst31_26 = head_inst[31:26];
    assign inst25_0  = head_inst[25:0];
    assign inst25_21 = head_inst[25:21];
    assign inst20_16 = head_inst[20:16];
    assign inst15_0  = head_inst[15:0];
    assign inst15_11 = head_inst[15:11];
    assign inst10_6  = head_inst[10:6];
    assign inst5_0   = head_inst[5:0];
    assign count     = cnt;

endmodule

// File: tb/tb_ir_fetch_queue.sv
// Bench for ir_fetch_queue: DEPTH=4 and DEPTH=3 instances share stimulus, each checked against a queue model.
module tb_ir_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] pc_ctr = 32'h0040_0000;

    always #5 clk = ~clk;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_pc;
    logic [5:0]  a_op, a_fn;
    logic [25:0] a_j;
    logic [4:0]  a_rs, a_rt, a_rd, a_sh;
    logic [15:0] a_imm;
    logic [2:0]  a_count;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_pc;
    logic [5:0]  b_op, b_fn;
    logic [25:0] b_j;
    logic [4:0]  b_rs, b_rt, b_rd, b_sh;
    logic [15:0] b_imm;
    logic [1:0]  b_count;

    ir_fetch_queue #(.DEPTH(4), .PC_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
        .inst31_26(a_op), .inst25_0(a_j), .inst25_21(a_rs), .inst20_16(a_rt),
        .inst15_0(a_imm), .inst15_11(a_rd), .inst10_6(a_sh), .inst5_0(a_fn),
        .count(a_count)
    );

    ir_fetch_queue #(.DEPTH(3), .PC_W(32)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
        .inst31_26(b_op), .inst25_0(b_j), .inst25_21(b_rs), .inst20_16(b_rt),
        .inst15_0(b_imm), .inst15_11(b_rd), .inst10_6(b_sh), .inst5_0(b_fn),
        .count(b_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: one queue of {pc,inst} per instance
`ifdef IR_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic [63:0] q0 [$];
    logic [63:0] q1 [$];
    logic [63:0] last_m [2];

    function automatic int msize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int mdepth(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic bit m_in_ready(input int k);
        return (msize(k) != mdepth(k)) && !flush;
    endfunction

    function automatic bit m_byp(input int k);
        return BYP && (msize(k) == 0) && in_valid && !flush;
    endfunction

    function automatic bit m_out_valid(input int k);
        return (msize(k) != 0) || m_byp(k);
    endfunction

    function automatic logic [63:0] m_head(input int k);
        if (msize(k) != 0)
            return (k == 0) ? q0[0] : q1[0];
        if (m_byp(k))
            return {in_pc, in_inst};
        return last_m[k];
    endfunction

    always @(posedge clk or negedge rst_n) begin : model_p
        bit          ir, ov, byp;
        logic [63:0] h;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            last_m[0] = '0;
            last_m[1] = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                ir  = m_in_ready(k);
                ov  = m_out_valid(k);
                byp = m_byp(k);
                h   = m_head(k);
                if (flush) begin
                    if (k == 0) q0.delete(); else q1.delete();
                end else begin
                    if (ov && out_ready) begin
                        last_m[k] = h;
                        if (msize(k) != 0) begin
                            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                        end
                    end
                    if (in_valid && ir && !(byp && out_ready)) begin
                        if (k == 0) q0.push_back({in_pc, in_inst}); else q1.push_back({in_pc, in_inst});
                    end
                end
            end
        end
    end

    task automatic cmp_inst(input string p, input int k, input logic ov, input logic ir,
                            input logic [2:0] cnt, input logic [31:0] pc, input logic [5:0] op,
                            input logic [25:0] j, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [15:0] imm, input logic [4:0] rd, input logic [4:0] sh,
                            input logic [5:0] fn);
        logic [63:0] h;
        h = m_head(k);
        chk({p, "_out_valid"}, 64'(ov), 64'(m_out_valid(k)));
        chk({p, "_in_ready"}, 64'(ir), 64'(m_in_ready(k)));
        chk({p, "_count"}, 64'(cnt), 64'(msize(k)));
        chk({p, "_out_pc"}, 64'(pc), 64'(h[63:32]));
        chk({p, "_opcode"}, 64'(op), 64'(h[31:26]));
        chk({p, "_target"}, 64'(j), 64'(h[25:0]));
        chk({p, "_rs"}, 64'(rs), 64'(h[25:21]));
        chk({p, "_rt"}, 64'(rt), 64'(h[20:16]));
        chk({p, "_imm"}, 64'(imm), 64'(h[15:0]));
        chk({p, "_rd"}, 64'(rd), 64'(h[15:11]));
        chk({p, "_shamt"}, 64'(sh), 64'(h[10:6]));
        chk({p, "_funct"}, 64'(fn), 64'(h[5:0]));
    endtask

    always @(negedge clk) begin : compare_p
        cmp_inst("a", 0, a_out_valid, a_in_ready, a_count, a_out_pc, a_op, a_j,
                 a_rs, a_rt, a_imm, a_rd, a_sh, a_fn);
        cmp_inst("b", 1, b_out_valid, b_in_ready, {1'b0, b_count}, b_out_pc, b_op, b_j,
                 b_rs, b_rt, b_imm, b_rd, b_sh, b_fn);
    end

    // ---------------- stimulus
    task automatic drv(input bit iv, input logic [31:0] ii, input bit ordy, input bit fl);
        in_valid  = iv;
        in_inst   = ii;
        in_pc     = pc_ctr;
        pc_ctr    = pc_ctr + 32'd4;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] a_head();
        return {a_op, a_j};
    endfunction

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_count", 64'(a_count), 64'd0);
        chk("rst_fields", 64'(a_head()), 64'd0);
        chk("rst_out_pc", 64'(a_out_pc), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);
        tick();

        // fill to DEPTH, then one more that must be dropped
        drv(1'b1, 32'h8C22_0004, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h0022_1820, 1'b0, 1'b0); tick();
        drv(1'b1, 32'hAC23_0008, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h1000_FFFF, 1'b0, 1'b0); tick();
        drv(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0); #1;
        chk("full_count", 64'(a_count), 64'd4);
        chk("full_in_ready", 64'(a_in_ready), 64'd0);
        tick();
        drv(1'b0, 32'h0, 1'b1, 1'b0); #1;
        chk("pop1_head", 64'(a_head()), 64'h8C22_0004);
        chk("pop1_imm", 64'(a_imm), 64'h0004);
        tick(); #1;
        chk("pop2_funct", 64'(a_fn), 64'h20);
        chk("pop2_head", 64'(a_head()), 64'h0022_1820);
        tick();

        // simultaneous push and pop at count=2
        drv(1'b1, 32'h2042_0001, 1'b1, 1'b0); tick(); #1;
        chk("pushpop_count", 64'(a_count), 64'd2);
        drv(1'b0, 32'h0, 1'b1, 1'b0); #1;
        chk("pushpop_2nd", 64'(a_head()), 64'h1000_FFFF);
        tick(); #1;
        chk("pushpop_3rd", 64'(a_head()), 64'h2042_0001);
        tick();

        // flush with a concurrent push
        drv(1'b1, 32'h014B_4820, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h0232_8822, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h8D09_0010, 1'b0, 1'b0); tick();
        drv(1'b0, 32'h0, 1'b1, 1'b0); tick();
        drv(1'b1, 32'hAD2A_0014, 1'b0, 1'b0); tick(); #1;
        chk("preflush_count", 64'(a_count), 64'd3);
        drv(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1); tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0); #1;
        chk("flush_count", 64'(a_count), 64'd0);
        chk("flush_out_valid", 64'(a_out_valid), 64'd0);
        chk("flush_hold", 64'(a_head()), 64'h014B_4820);

        // last entry popped: fields held
        drv(1'b1, 32'h0022_1820, 1'b0, 1'b0); tick();
        drv(1'b0, 32'h0, 1'b1, 1'b0); tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0); #1;
        chk("hold_out_valid", 64'(a_out_valid), 64'd0);
        chk("hold_rd", 64'(a_rd), 64'd3);
        chk("hold_funct", 64'(a_fn), 64'h20);
        repeat (5) tick();
        chk("hold_rd_later", 64'(a_rd), 64'd3);
        chk("hold_funct_later", 64'(a_fn), 64'h20);

        // reset with three entries queued
        drv(1'b1, 32'h1111_1111, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h2222_2222, 1'b0, 1'b0); tick();
        drv(1'b1, 32'h3333_3333, 1'b0, 1'b0); tick();
        drv(1'b0, 32'h0, 1'b0, 1'b0); #1;
        chk("midrst_pre_count", 64'(a_count), 64'd3);
        rst_n = 1'b0; #1;
        chk("midrst_out_valid", 64'(a_out_valid), 64'd0);
        chk("midrst_count", 64'(a_count), 64'd0);
        chk("midrst_fields", 64'(a_head()), 64'd0);
        chk("midrst_out_pc", 64'(a_out_pc), 64'd0);
        tick();
        rst_n = 1'b1; #1;
        chk("midrst_in_ready", 64'(a_in_ready), 64'd1);
        tick();

        // empty queue, word offered while consumer is ready
        drv(1'b1, 32'h0800_0010, 1'b1, 1'b0); #1;
`ifdef IR_FETCH_BYPASS_EN
        chk("byp_out_valid", 64'(a_out_valid), 64'd1);
        chk("byp_target", 64'(a_j), 64'h000_0010);
        tick();
        chk("byp_count", 64'(a_count), 64'd0);
`else
        chk("nobyp_out_valid", 64'(a_out_valid), 64'd0);
        tick();
        chk("nobyp_count", 64'(a_count), 64'd1);
        chk("nobyp_out_valid_next", 64'(a_out_valid), 64'd1);
        chk("nobyp_target", 64'(a_j), 64'h000_0010);
`endif
        drv(1'b0, 32'h0, 1'b0, 1'b0); tick();
        drv(1'b0, 32'h0, 1'b1, 1'b0); tick();

        // randomized traffic with shifting producer/consumer pressure
        for (int i = 0; i < 3000; i++) begin
            int pv, pr;
            pv = (i < 1000) ? 85 : (i < 2000) ? 30 : 60;
            pr = (i < 1000) ? 30 : (i < 2000) ? 85 : 60;
            if ($urandom_range(0, 699) == 0) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            drv($urandom_range(0, 99) < pv, $urandom, $urandom_range(0, 99) < pr,
                $urandom_range(0, 39) == 0);
            tick();
        end

        drv(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
